// File: rtl/pc_unit.sv
// Fetch-stage program counter: boot hold window, stall handling with a one-entry
// redirect/exception buffer that is applied when the stall releases.
module pc_unit #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h80),
    parameter int                INC          = 4,
    parameter int                BOOT_DELAY   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              exc_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              pc_valid,
    output logic              redirect_pending
);

    localparam int                CNT_W      = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [ADDR_W-1:0] INC_V      = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(INC_V - ADDR_W'(1));

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_nx, pend_pc, pend_pc_nx, redirect_aligned;
    logic              pend_exc, pend_exc_nx, pending_nx, valid_nx;
    logic [CNT_W-1:0]  boot_cnt, boot_cnt_nx;

    assign npc              = pc + INC_V;
    assign redirect_aligned = redirect_pc & ALIGN_MASK;

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        valid_nx    = pc_valid;
        pending_nx  = redirect_pending;
        pend_pc_nx  = pend_pc;
        pend_exc_nx = pend_exc;
        boot_cnt_nx = boot_cnt;
        case (state)
            BOOT: begin
                boot_cnt_nx = boot_cnt + CNT_W'(1);
                if (boot_cnt == CNT_W'(BOOT_DELAY - 1)) begin
                    state_nx = RUN;
                    valid_nx = 1'b1;
                end
            end
            RUN: begin
                if (stall) begin
                    state_nx = HOLD;
                    if (exc_valid) begin
                        pend_pc_nx  = EXC_VECTOR;
                        pend_exc_nx = 1'b1;
                        pending_nx  = 1'b1;
                    end else if (redirect_valid) begin
                        pend_pc_nx  = redirect_aligned;
                        pend_exc_nx = 1'b0;
                        pending_nx  = 1'b1;
                    end
                end else if (exc_valid) begin
                    pc_nx = EXC_VECTOR;
                end else if (redirect_valid) begin
                    pc_nx = redirect_aligned;
                end else begin
                    pc_nx = npc;
                end
            end
            HOLD: begin
                if (stall) begin
                    // A buffered exception outranks any later redirect.
                    if (exc_valid) begin
                        pend_pc_nx  = EXC_VECTOR;
                        pend_exc_nx = 1'b1;
                        pending_nx  = 1'b1;
                    end else if (redirect_valid && !pend_exc) begin
                        pend_pc_nx = redirect_aligned;
                        pending_nx = 1'b1;
                    end
                end else begin
                    state_nx    = RUN;
                    pending_nx  = 1'b0;
                    pend_exc_nx = 1'b0;
                    if (exc_valid)             pc_nx = EXC_VECTOR;
                    else if (pend_exc)         pc_nx = pend_pc;
                    else if (redirect_valid)   pc_nx = redirect_aligned;
                    else if (redirect_pending) pc_nx = pend_pc;
                    else                       pc_nx = npc;
                end
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= BOOT;
            pc               <= RESET_VECTOR;
            pc_valid         <= 1'b0;
            redirect_pending <= 1'b0;
            pend_pc          <= '0;
            pend_exc         <= 1'b0;
            boot_cnt         <= '0;
        end else begin
            state            <= state_nx;
            pc               <= pc_nx;
            pc_valid         <= valid_nx;
            redirect_pending <= pending_nx;
            pend_pc          <= pend_pc_nx;
            pend_exc         <= pend_exc_nx;
            boot_cnt         <= boot_cnt_nx;
        end
    end

endmodule
